// File: rtl/evento_cola.sv
// Event queue between the debounced inputs and the pet state machine: every toggle
// becomes an event code, simultaneous events are arbitrated by fixed priority and buffered.
module evento_cola #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     senal_reset,
  input  logic                     senal_test,
  input  logic                     senal_medicina,
  input  logic                     senal_energia,
  input  logic                     senal_ultrasonido,
  input  logic                     senal_fot,
  output logic                     evt_valid,
  output logic [CW-1:0]            evt_code,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     evt_drop
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            NS   = 6;
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  // Bit 0 is the highest-priority source; event code is bit index + 1.
  logic [NS-1:0] sig, prev, pending, change, grant, pending_next;
  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] code_in;
  logic          pop, push, space, drop_hit;

  assign sig       = {senal_fot, senal_ultrasonido, senal_energia,
                      senal_medicina, senal_test, senal_reset};
  assign change    = sig ^ prev;
  assign evt_valid = (evt_count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : '0;
  assign pop       = evt_valid && evt_ready;
  assign space     = (evt_count < FULL) || pop;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant   = '0;
    code_in = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (space && pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        code_in  = CW'(i + 1);
      end
    end
  end

  assign push = |grant;
  // A change on the edge its pending bit is enqueued starts a new event rather than a drop.
  assign pending_next = (pending & ~grant) | change;
  assign drop_hit     = |(change & pending & ~grant);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    prev <= sig;
    if (reset) begin
      pending   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      evt_count <= '0;
      evt_drop  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (drop_hit) evt_drop <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only visible once the pointers mark them valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

endmodule

// File: tb/tb_evento_cola.sv
// Self-checking bench for evento_cola: scenario tasks with a queue of expected event codes
// pushed at stimulus time and compared as the consumer pops them.
module tb_evento_cola;

  logic       clk;
  logic       reset;
  logic [5:0] s;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
  logic       evt_drop;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  evento_cola #(.DEPTH(4), .CW(3)) dut (
    .clk               (clk),
    .reset             (reset),
    .senal_reset       (s[0]),
    .senal_test        (s[1]),
    .senal_medicina    (s[2]),
    .senal_energia     (s[3]),
    .senal_ultrasonido (s[4]),
    .senal_fot         (s[5]),
    .evt_valid         (evt_valid),
    .evt_code          (evt_code),
    .evt_ready         (evt_ready),
    .evt_count         (evt_count),
    .evt_drop          (evt_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; evt_ready = 1'b0; s = 6'b001000;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_idle_valid cyc %0d: got %b want 0", i, evt_valid);
      end
    end
    n_cmp++;
    if (evt_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", evt_count); end
    n_cmp++;
    if (evt_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", evt_drop); end
    n_cmp++;
    if (evt_code !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", evt_code); end
  endtask

  task automatic test_single();
    s[2] = ~s[2];
    exp_q.push_back(3'd3);
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_latency_early: valid %b want 0", evt_valid); end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", evt_valid); end
    n_cmp++;
    if (evt_code !== exp_q[0]) begin n_err++; $display("FAIL single_code: got %0d want %0d", evt_code, exp_q[0]); end
    n_cmp++;
    if (evt_count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", evt_count); end
    void'(exp_q.pop_front());
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
      n_err++; $display("FAIL single_pop: valid %b count %0d want 0/0", evt_valid, evt_count);
    end
  endtask

  // Consumer always ready: compare every popped code with the scoreboard head.
  task automatic drain_scoreboard(input string name, input int budget);
    int cyc = 0;
    evt_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < budget) begin
      if (evt_valid === 1'b1) begin
        n_cmp++;
        if (evt_code !== exp_q[0]) begin
          n_err++; $display("FAIL %s_code: got %0d want %0d", name, evt_code, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    evt_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s_timeout: %0d events missing want 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_err++; $display("FAIL %s_extra: valid %b want 0", name, evt_valid); end
  endtask

  task automatic test_priority();
    s[5] = ~s[5]; s[1] = ~s[1]; s[3] = ~s[3];
    exp_q.push_back(3'd2); exp_q.push_back(3'd4); exp_q.push_back(3'd6);
    tick(); tick();
    drain_scoreboard("priority", 12);
    n_cmp++;
    if (evt_drop !== 1'b0) begin n_err++; $display("FAIL priority_drop: got %b want 0", evt_drop); end
  endtask

  task automatic test_full_and_drop();
    s[0] = ~s[0]; s[1] = ~s[1]; s[2] = ~s[2]; s[3] = ~s[3]; s[4] = ~s[4];
    for (int c = 1; c <= 5; c++) exp_q.push_back(3'(c));
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (evt_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", evt_count); end
    n_cmp++;
    if (evt_drop !== 1'b0) begin n_err++; $display("FAIL full_nodrop: got %b want 0", evt_drop); end
    n_cmp++;
    if (evt_code !== exp_q[0]) begin n_err++; $display("FAIL full_head: got %0d want %0d", evt_code, exp_q[0]); end
    void'(exp_q.pop_front());
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_count !== 3'd4) begin n_err++; $display("FAIL full_push_pop_count: got %0d want 4", evt_count); end
    n_cmp++;
    if (evt_code !== exp_q[0]) begin n_err++; $display("FAIL full_next_head: got %0d want %0d", evt_code, exp_q[0]); end
    s[1] = ~s[1];
    exp_q.push_back(3'd2);
    tick();
    n_cmp++;
    if (evt_drop !== 1'b0) begin n_err++; $display("FAIL first_toggle_drop: got %b want 0", evt_drop); end
    s[1] = ~s[1];
    tick();
    n_cmp++;
    if (evt_drop !== 1'b1) begin n_err++; $display("FAIL second_toggle_drop: got %b want 1", evt_drop); end
    drain_scoreboard("full_drain", 20);
    n_cmp++;
    if (evt_drop !== 1'b1) begin n_err++; $display("FAIL drop_sticky: got %b want 1", evt_drop); end
  endtask

  task automatic test_mid_reset();
    s[2] = ~s[2]; s[3] = ~s[3]; s[5] = ~s[5];
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (evt_count !== 3'd3) begin n_err++; $display("FAIL mid_queued: got %0d want 3", evt_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0 || evt_drop !== 1'b0 || evt_code !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset: valid %b count %0d drop %b code %0d want 0/0/0/0",
               evt_valid, evt_count, evt_drop, evt_code);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (evt_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_quiet cyc %0d: valid %b want 0", i, evt_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_full_and_drop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/evento_cola.md
Name: evento_cola

Overview:
- Sits between the debounced-button/sensor block and the pet state machine.
- The upstream block presents each button or sensor as a level that toggles once per debounced press or detection.
- This block turns every toggle into a discrete event code, arbitrates simultaneous events by fixed priority, and buffers them in a small FIFO.
- The state machine consumes events through a valid/ready handshake, so no press is lost while it is busy.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, 3, event-code width in bits.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- senal_reset  input  1  toggle level from the reset button.
- senal_test  input  1  toggle level from the test button.
- senal_medicina  input  1  toggle level from the medicine button.
- senal_energia  input  1  toggle level from the energy button.
- senal_ultrasonido  input  1  toggle level from the ultrasonic sensor.
- senal_fot  input  1  toggle level from the photocell.
- evt_valid  output  1  FIFO not empty; evt_code is meaningful.
- evt_code  output  CW  event at the FIFO head.
- evt_ready  input  1  consumer accepts the head this cycle.
- evt_count  output  clog2(DEPTH)+1  current FIFO occupancy.
- evt_drop  output  1  sticky flag; an event was lost.

Behaviour:
- Event codes:
  - 1 reset, 2 test, 3 medicina, 4 energia, 5 ultrasonido, 6 fot.
  - Codes 0 and 7 are never produced.
- Priority (highest first): reset, test, medicina, energia, ultrasonido, fot.
- Reset:
  - FIFO is emptied: evt_valid=0, evt_count=0, evt_code=0.
  - evt_drop=0; all pending bits cleared.
  - Previous-value registers load the current input levels, so no event is produced for whatever level the inputs hold at reset release.
  - A reset asserted mid-operation discards all queued and pending events in that same edge.
- Edge capture (edge k):
  - prev_x <= senal_x.
  - Change detected when senal_x != prev_x.
  - A change sets pending_x at edge k.
- Coalescing:
  - A change while pending_x is already set, and pending_x is not being consumed at that edge, is lost: pending_x stays 1 and evt_drop <= 1.
  - A change on the same edge that pending_x is enqueued re-sets pending_x. This is a new event, not a drop.
- Arbitration (each edge):
  - If FIFO has space, the highest-priority set pending bit is written to the tail, and that bit is cleared.
  - At most one enqueue per cycle.
  - Space = (evt_count < DEPTH) or a pop occurs on the same edge.
- Latency:
  - Toggle seen at edge k gives evt_valid=1 after edge k+1, when the FIFO was empty and no higher-priority bit was pending.
- Pop:
  - Occurs when evt_valid && evt_ready.
  - The head advances at that edge.
  - evt_ready while empty has no effect.
- Simultaneous push and pop: evt_count unchanged; order preserved.
- Full FIFO with no pop: pending bits hold; no drop until a second toggle of the same source arrives.
- FIFO storage:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - evt_code is driven directly from the head entry; no extra cycle after pop.
- evt_drop clears only on reset.
- Inputs are assumed synchronous to clk; the block adds no synchronizers.

Test Plan:
- Reset release with senal_energia=1 and all others 0, idle 10 cycles -> evt_valid=0, evt_count=0, evt_drop=0.
- Single toggle of senal_medicina at edge 5, evt_ready=0 -> evt_valid=1 and evt_code=3 after edge 6, evt_count=1; evt_ready=1 for one cycle -> evt_valid=0 after the next edge.
- senal_fot, senal_test and senal_energia toggled on the same edge, evt_ready=1 -> codes appear in order 2, 4, 6 on consecutive cycles; evt_drop=0.
- DEPTH=4, evt_ready=0, toggle five distinct sources once each (reset, test, medicina, energia, ultrasonido) -> evt_count=4, fifth held pending, evt_drop=0; one pop -> fifth enqueued on that edge, evt_count stays 4.
- With FIFO full, toggle senal_test twice -> evt_drop=1 after the second toggle edge; the flag persists until reset.
- Three entries queued, assert reset for one cycle -> evt_valid=0, evt_count=0, evt_drop=0 after that edge; no events emitted afterwards without a new toggle.
